sample_fetch_master: RTL and testbench
======================================

SAMPLE_FETCH_MASTER -- requirements
Module: sample_fetch_master

Interface
REQ-001 Parameter ADDR_W, default 16, word-address width on the memory side.
REQ-002 Parameter DATA_W, default 32, data width of memory and stream.
REQ-003 Parameter FIFO_DEPTH, default 4, output buffer depth in words (power of 2, >=2).
REQ-004 One clock; reset is synchronous and active-high; ports named clk and reset.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  single-cycle command pulse; sampled only in IDLE.
REQ-008 base_addr  in  ADDR_W  first word address; sampled on accepted start.
REQ-009 word_count  in  ADDR_W+1  words per pass, 0..2^ADDR_W; sampled on accepted start.
REQ-010 loop  in  1  1 = restart at base_addr after last word; sampled on accepted start.
REQ-011 abort  in  1  single-cycle stop request; honoured in any non-IDLE state.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 done  out  1  one-cycle pulse on normal completion.
REQ-014 address  out  ADDR_W  memory word address.
REQ-015 byteenable  out  DATA_W/8  constant all-ones.
REQ-016 chipselect  out  1  read request strobe.
REQ-017 write  out  1  constant 0.
REQ-018 writedata  out  DATA_W  constant 0.
REQ-019 clken  out  1  constant 1.
REQ-020 readdata  in  DATA_W  memory read data.
REQ-021 out_data  out  DATA_W  stream word.
REQ-022 out_valid  out  1  stream word valid.
REQ-023 out_ready  in  1  sink ready; transfer when out_valid & out_ready.

Function
REQ-024 The memory read latency SHALL be exactly 1: readdata for the request issued in cycle N is captured into the FIFO at the end of cycle N+1.
REQ-025 States: IDLE, FETCH, DRAIN; IDLE->FETCH on start with word_count!=0; IDLE stays IDLE on start with word_count==0, with done pulsing the following cycle.
REQ-026 In FETCH, a read is issued (chipselect=1) in a cycle only if FIFO occupancy + in-flight reads < FIFO_DEPTH, counting the word popped that cycle as freed.
REQ-027 Address sequence base_addr, base_addr+1, ..., computed modulo 2^ADDR_W (0xFFFF wraps to 0x0000 mid-pass).
REQ-028 After issuing word word_count-1: loop=1 -> next address base_addr, remain in FETCH; loop=0 -> FETCH->DRAIN.
REQ-029 DRAIN->IDLE once no read is in flight and FIFO is empty; done pulses in the cycle busy falls.
REQ-030 Stream order equals address issue order; no word dropped or duplicated under any out_ready pattern.
REQ-031 Full FIFO with out_ready=1: push and pop in the same cycle are both honoured.
REQ-032 out_valid = FIFO not empty; out_data = FIFO head, stable while out_valid & !out_ready.
REQ-033 start while busy SHALL be ignored.
REQ-034 abort: next cycle state=IDLE, FIFO flushed, chipselect=0, done not pulsed; the in-flight readdata is discarded.
REQ-035 abort and start in the same IDLE cycle: start is accepted and abort ignored.
REQ-036 Sustained throughput with out_ready=1 SHALL be one word per cycle after a 2-cycle initial latency (start to first out_valid).

Reset
REQ-037 On reset: state IDLE, FIFO empty, in-flight cleared; busy=0, done=0, chipselect=0, address=0, out_valid=0, out_data=0.
REQ-038 Constant outputs (byteenable all-ones, write=0, writedata=0, clken=1) are unaffected by reset.
REQ-039 Reset mid-transfer behaves as abort, with no done pulse and no stale word emitted afterwards.

Structure
REQ-040 Package sfm_pkg holds the state enum (IDLE, FETCH, DRAIN) and default width/depth constants.
REQ-041 FIFO is one sub-module, sfm_fifo (synchronous, registered occupancy count, same-cycle push/pop).

Verification
REQ-042 Memory model: 1-cycle latency, mem[i]=i*0x01010101; start base=0x0010 count=8 loop=0, out_ready=1 -> words 0x10101010..0x17171717 on 8 consecutive cycles, done once.
REQ-043 base=0xFFFE count=4 -> addresses FFFE, FFFF, 0000, 0001 in order.
REQ-044 out_ready random 30% duty, count=100 -> 100 words in order, FIFO occupancy never exceeds FIFO_DEPTH.
REQ-045 loop=1 count=3 base=5, then abort after 10 words -> stream 5,6,7,5,6,7,...; IDLE next cycle, no done, no further out_valid.
REQ-046 start with count=0 -> no chipselect, done pulses one cycle later; start while busy -> ignored.
REQ-047 reset asserted mid-FETCH with FIFO full -> all outputs at reset values next cycle, no further stream words.

Source files
------------

// File: rtl/sfm_pkg.sv
// rtl/sfm_pkg.sv - shared state encoding and default sizing for the sample fetch master
package sfm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int SFM_ADDR_W     = 16;
    localparam int SFM_DATA_W     = 32;
    localparam int SFM_FIFO_DEPTH = 4;

endpackage

// File: rtl/sfm_fifo.sv
// rtl/sfm_fifo.sv - synchronous output buffer with registered occupancy and same-cycle push/pop
module sfm_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        head_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;

    // The producer never pushes into a full buffer unless it also pops that cycle.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/sample_fetch_master.sv
// rtl/sample_fetch_master.sv - sequential memory reader streaming words through a small buffer
module sample_fetch_master
    import sfm_pkg::*;
#(
    parameter int ADDR_W     = SFM_ADDR_W,
    parameter int DATA_W     = SFM_DATA_W,
    parameter int FIFO_DEPTH = SFM_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       word_count,
    input  logic                  loop,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     address,
    output logic [DATA_W/8-1:0]   byteenable,
    output logic                  chipselect,
    output logic                  write,
    output logic [DATA_W-1:0]     writedata,
    output logic                  clken,
    input  logic [DATA_W-1:0]     readdata,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]    DEPTH_L = (CW+1)'(FIFO_DEPTH);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, base_q, base_d;
    logic [ADDR_W:0]     remain_q, remain_d, count_q, count_d;
    logic                loop_q, loop_d;
    logic                inflight_q, inflight_d;
    logic                done_q, done_d;

    logic                issue, kill, pop, push, room;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [DATA_W-1:0]   fifo_head;
    logic [CW:0]         occ_after;

    logic [ADDR_W-1:0]   cur_addr, cur_base;
    logic [ADDR_W:0]     cur_remain, cur_count;
    logic                cur_loop;

    // The first read is issued in the start cycle itself, straight from the command inputs.
    assign cur_addr   = (state_q == IDLE) ? base_addr  : addr_q;
    assign cur_base   = (state_q == IDLE) ? base_addr  : base_q;
    assign cur_remain = (state_q == IDLE) ? word_count : remain_q;
    assign cur_count  = (state_q == IDLE) ? word_count : count_q;
    assign cur_loop   = (state_q == IDLE) ? loop       : loop_q;

    assign kill = abort && (state_q != IDLE);
    assign pop  = !fifo_empty && out_ready;
    assign push = inflight_q && !kill;

    // Occupancy plus the read returning this cycle, less the word leaving this cycle.
    assign occ_after = {1'b0, fifo_count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign room      = (occ_after < DEPTH_L);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        base_d     = base_q;
        count_d    = count_q;
        remain_d   = remain_q;
        loop_d     = loop_q;
        inflight_d = 1'b0;
        done_d     = 1'b0;
        issue      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    count_d = word_count;
                    loop_d  = loop;
                    if (word_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        issue   = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (abort) state_d = IDLE;
                else       issue   = room;
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!inflight_q && fifo_count == CW'(pop)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            inflight_d = 1'b1;
            if (cur_remain == (ADDR_W+1)'(1)) begin
                if (cur_loop) begin
                    addr_d   = cur_base;
                    remain_d = cur_count;
                end else begin
                    addr_d  = cur_addr + ADDR_W'(1);
                    state_d = DRAIN;
                end
            end else begin
                addr_d   = cur_addr + ADDR_W'(1);
                remain_d = cur_remain - (ADDR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            base_q     <= '0;
            count_q    <= '0;
            remain_q   <= '0;
            loop_q     <= 1'b0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            base_q     <= base_d;
            count_q    <= count_d;
            remain_q   <= remain_d;
            loop_q     <= loop_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    sfm_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (kill),
        .push_i      (push),
        .push_data_i (readdata),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign chipselect = issue;
    assign address    = (state_q == IDLE && issue) ? base_addr : addr_q;
    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_empty ? '0 : fifo_head;

    assign byteenable = '1;
    assign write      = 1'b0;
    assign writedata  = '0;
    assign clken      = 1'b1;

endmodule

// File: tb/tb_sample_fetch_master.sv
// tb/tb_sample_fetch_master.sv - directed vector bench for sample_fetch_master
module tb_sample_fetch_master;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, start, loop, abort, out_ready;
    logic [15:0] base_addr;
    logic [16:0] word_count;
    logic        busy, done, chipselect, write, clken, out_valid;
    logic [15:0] address;
    logic [3:0]  byteenable;
    logic [31:0] writedata, readdata, out_data;

    sample_fetch_master dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .loop(loop), .abort(abort), .busy(busy),
        .done(done), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .write(write), .writedata(writedata),
        .clken(clken), .readdata(readdata), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {16'b0, a} * 32'h01010101;
    endfunction

    always @(posedge clk) readdata <= chipselect ? mem_word(address) : 32'hDEADBEEF;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] got_q[$];
    int          got_cyc[$];
    logic [15:0] adr_q[$];
    int          done_cnt, occ_model, occ_err, stall_err;
    logic        cs_prev, last_stall;
    logic [31:0] last_data;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            got_cyc.push_back(cyc);
        end
        if (chipselect) adr_q.push_back(address);
        if (done) done_cnt++;
        if (occ_model > DEPTH || out_valid != (occ_model != 0)) occ_err++;
        if (last_stall && out_data != last_data) stall_err++;
        last_stall = out_valid && !out_ready;
        last_data  = out_data;
        occ_model  = occ_model + int'(cs_prev) - int'(out_valid && out_ready);
        cs_prev    = chipselect;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        got_q.delete(); got_cyc.delete(); adr_q.delete();
        done_cnt = 0; occ_model = 0; occ_err = 0; stall_err = 0;
        cs_prev = 1'b0; last_stall = 1'b0;
    endtask

    task automatic tick(input int mode);
        @(posedge clk);
        #1;
        case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 9) < 3);
            2:       out_ready = cyc[0];
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic wait_done(input int mode, input int budget);
        for (int k = 0; k < budget && done_cnt == 0; k++) tick(mode);
    endtask

    typedef struct {
        logic [15:0] base;
        logic [16:0] count;
        int          mode;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        logic [15:0] exp_last_addr;
    } vec_t;

    vec_t vecs[5];
    int   start_cyc;

    task automatic reset_outputs(input string tag);
        check({tag, " busy"},       busy,       0);
        check({tag, " done"},       done,       0);
        check({tag, " chipselect"}, chipselect, 0);
        check({tag, " address"},    address,    0);
        check({tag, " out_valid"},  out_valid,  0);
        check({tag, " out_data"},   out_data,   0);
        check({tag, " byteenable"}, byteenable, 4'hF);
        check({tag, " write"},      write,      0);
        check({tag, " writedata"},  writedata,  0);
        check({tag, " clken"},      clken,      1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; loop = 1'b0; abort = 1'b0; out_ready = 1'b0;
        base_addr = '0; word_count = '0;
        clr_mon();
        vecs[0] = '{16'h0010, 17'd8,   0, 32'h10101010, 32'h17171717, 16'h0017};
        vecs[1] = '{16'hFFFE, 17'd4,   0, 32'hFEFEFDFE, 32'h01010101, 16'h0001};
        vecs[2] = '{16'h0100, 17'd100, 1, 32'h01010100, 32'h64646463, 16'h0163};
        vecs[3] = '{16'h0003, 17'd1,   0, 32'h03030303, 32'h03030303, 16'h0003};
        vecs[4] = '{16'h0020, 17'd5,   2, 32'h20202020, 32'h24242424, 16'h0024};

        repeat (3) tick(3);
        reset = 1'b0;
        #1;
        reset_outputs("reset");

        for (int v = 0; v < 5; v++) begin
            int bad;
            int n;
            clr_mon();
            tick(vecs[v].mode);
            start = 1'b1; base_addr = vecs[v].base; word_count = vecs[v].count; loop = 1'b0;
            start_cyc = cyc;
            tick(vecs[v].mode);
            start = 1'b0;
            wait_done(vecs[v].mode, 2000);
            repeat (3) tick(0);
            n = got_q.size();
            check($sformatf("v%0d words", v),     n, vecs[v].count);
            check($sformatf("v%0d first", v),     n > 0 ? got_q[0] : 32'hX, vecs[v].exp_first);
            check($sformatf("v%0d last", v),      n > 0 ? got_q[n-1] : 32'hX, vecs[v].exp_last);
            bad = 0;
            for (int i = 0; i < n; i++)
                if (got_q[i] !== mem_word(vecs[v].base + 16'(i))) bad++;
            check($sformatf("v%0d order", v), bad, 0);
            bad = 0;
            for (int i = 0; i < adr_q.size(); i++)
                if (adr_q[i] !== vecs[v].base + 16'(i)) bad++;
            check($sformatf("v%0d addr_seq", v), bad, 0);
            check($sformatf("v%0d last_addr", v),
                  adr_q.size() > 0 ? adr_q[adr_q.size()-1] : 16'hX, vecs[v].exp_last_addr);
            check($sformatf("v%0d done_cnt", v),  done_cnt, 1);
            check($sformatf("v%0d busy_end", v),  busy, 0);
            check($sformatf("v%0d occupancy", v), occ_err, 0);
            check($sformatf("v%0d stable", v),    stall_err, 0);
            if (vecs[v].mode == 0) begin
                check($sformatf("v%0d latency", v), n > 0 ? got_cyc[0] - start_cyc : -1, 2);
                check($sformatf("v%0d span", v), n > 0 ? got_cyc[n-1] - got_cyc[0] : -1,
                      vecs[v].count - 1);
            end
        end

        // zero-length command: no read, done on the following cycle
        clr_mon();
        tick(0);
        start = 1'b1; base_addr = 16'h0300; word_count = '0;
        #1;
        check("zero cs_in_start", chipselect, 0);
        tick(0);
        start = 1'b0;
        #1;
        check("zero done", done, 1);
        check("zero busy", busy, 0);
        tick(0);
        #1;
        check("zero done_once", done, 0);
        check("zero no_reads", adr_q.size(), 0);

        // a second start while busy must not disturb the running pass
        clr_mon();
        tick(0);
        start = 1'b1; base_addr = 16'h0040; word_count = 17'd6;
        tick(0);
        start = 1'b0;
        tick(0);
        start = 1'b1; base_addr = 16'h0080; word_count = 17'd2;
        tick(0);
        start = 1'b0;
        wait_done(0, 200);
        repeat (4) tick(0);
        check("busy_start words", got_q.size(), 6);
        check("busy_start last", got_q.size() == 6 ? got_q[5] : 32'hX, 32'h45454545);
        check("busy_start done_cnt", done_cnt, 1);

        // looping pass, aborted after ten words
        clr_mon();
        tick(0);
        start = 1'b1; base_addr = 16'h0005; word_count = 17'd3; loop = 1'b1;
        tick(0);
        start = 1'b0; loop = 1'b0;
        for (int k = 0; k < 100 && got_q.size() < 10; k++) tick(0);
        abort = 1'b1; out_ready = 1'b0;
        tick(0);
        abort = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort out_valid", out_valid, 0);
        check("abort chipselect", chipselect, 0);
        repeat (10) tick(0);
        begin
            int bad = 0;
            for (int i = 0; i < got_q.size(); i++)
                if (got_q[i] !== mem_word(16'(5 + i % 3))) bad++;
            check("abort pattern", bad, 0);
        end
        check("abort words", got_q.size(), 10);
        check("abort no_done", done_cnt, 0);

        // reset with the buffer full and the sink stalled
        clr_mon();
        tick(3);
        start = 1'b1; base_addr = 16'h0200; word_count = 17'd20;
        tick(3);
        start = 1'b0;
        repeat (8) tick(3);
        check("full reads_issued", adr_q.size(), DEPTH);
        check("full cs_held", chipselect, 0);
        check("full head", out_data, mem_word(16'h0200));
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        #1;
        reset_outputs("midreset");
        repeat (10) tick(0);
        check("midreset no_words", got_q.size(), 0);
        check("midreset no_done", done_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

endmodule
